pb_port_controller: RTL and testbench

//  PicoBlaze-side I/O glue for the audio recorder/player, in the clk100mhz domain.

---
 rtl/pb_port_controller.sv | 152 +++++++++++++++
 tb/tb_pb_port_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_port_controller.sv
// PicoBlaze I/O glue: registered input-port mux, UART strobes, one-hot transport
// mode register and debounced, saturating codec volume control.

module pb_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk100mhz,
  input  logic pb_reset,
  input  logic i_btn,
  output logic o_ondn
);
  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_state;
  logic             r_ondn;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk100mhz or posedge pb_reset) begin
    if (pb_reset) begin
      r_sync  <= '0;
      r_state <= 1'b0;
      r_ondn  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_ondn <= 1'b0;
      if (r_sync[1] == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // Level has differed for CYCLES consecutive cycles: accept it.
        r_cnt   <= '0;
        r_state <= ~r_state;
        r_ondn  <= ~r_state;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Release edges are never consumed by the volume logic, so only the
  // press pulse is brought out.
  assign o_ondn = r_ondn;
endmodule

module pb_port_controller #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [1:0] VOL_RESET       = 2'd1
) (
  input  logic       clk100mhz,
  input  logic       pb_reset,
  input  logic [7:0] pb_port_id,
  input  logic [7:0] pb_out_port,
  input  logic       pb_read_strobe,
  input  logic       pb_write_strobe,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_data_present,
  input  logic       uart_buffer_full,
  input  logic       deletedall,
  input  logic       volup,
  input  logic       voldown,
  output logic [7:0] pb_in_port,
  output logic       read_from_uart,
  output logic       write_to_uart,
  output logic       record,
  output logic       play,
  output logic       delete,
  output logic       pause,
  output logic       delete_all,
  output logic [1:0] volume_control
);
  logic [7:0] r_in_port;
  logic       r_read_uart;
  logic       r_record, r_play, r_delete, r_pause, r_delete_all;
  logic [1:0] r_vol;
  logic       w_up_press, w_dn_press;
  logic       w_mode_wr;

  // Input mux is registered every cycle, whether or not a read strobe is present.
  always_ff @(posedge clk100mhz or posedge pb_reset) begin
    if (pb_reset) begin
      r_in_port   <= 8'h00;
      r_read_uart <= 1'b0;
    end else begin
      r_read_uart <= pb_read_strobe & (pb_port_id == 8'h04);
      case (pb_port_id)
        8'h02:   r_in_port <= uart_rx_data;
        8'h04:   r_in_port <= {7'b0, uart_data_present};
        8'h05:   r_in_port <= {7'b0, uart_buffer_full};
        8'h07:   r_in_port <= {7'b0, deletedall};
        default: r_in_port <= 8'h00;
      endcase
    end
  end

  assign w_mode_wr = pb_write_strobe & (pb_port_id == 8'h06);

  // Each write decodes a fresh one-hot value; unknown codes leave all bits clear.
  always_ff @(posedge clk100mhz or posedge pb_reset) begin
    if (pb_reset) begin
      r_play       <= 1'b0;
      r_record     <= 1'b0;
      r_delete     <= 1'b0;
      r_pause      <= 1'b0;
      r_delete_all <= 1'b0;
    end else if (w_mode_wr) begin
      r_play       <= (pb_out_port == 8'h00);
      r_record     <= (pb_out_port == 8'h01);
      r_delete     <= (pb_out_port == 8'h02);
      r_pause      <= (pb_out_port == 8'h03);
      r_delete_all <= (pb_out_port == 8'h04);
    end
  end

  pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk100mhz (clk100mhz),
    .pb_reset  (pb_reset),
    .i_btn     (volup),
    .o_ondn    (w_up_press)
  );

  pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk100mhz (clk100mhz),
    .pb_reset  (pb_reset),
    .i_btn     (voldown),
    .o_ondn    (w_dn_press)
  );

  // An up press always wins the cycle, even when it cannot increment.
  always_ff @(posedge clk100mhz or posedge pb_reset) begin
    if (pb_reset) begin
      r_vol <= VOL_RESET;
    end else if (w_up_press) begin
      if (r_vol != 2'd3) r_vol <= r_vol + 2'd1;
    end else if (w_dn_press && r_vol != 2'd0) begin
      r_vol <= r_vol - 2'd1;
    end
  end

  assign pb_in_port     = r_in_port;
  assign read_from_uart = r_read_uart;
  assign write_to_uart  = pb_write_strobe & (pb_port_id == 8'h03);
  assign record         = r_record;
  assign play           = r_play;
  assign delete         = r_delete;
  assign pause          = r_pause;
  assign delete_all     = r_delete_all;
  assign volume_control = r_vol;
endmodule

// File: tb/tb_pb_port_controller.sv
// Scoreboard bench for pb_port_controller: the driver pushes expectations from a
// behavioural model, a negedge monitor pops and compares them against the DUT.

module tb_pb_port_controller;
  localparam int DB = 4;

  logic       clk100mhz = 1'b0;
  logic       pb_reset;
  logic [7:0] pb_port_id, pb_out_port, uart_rx_data;
  logic       pb_read_strobe, pb_write_strobe;
  logic       uart_data_present, uart_buffer_full, deletedall;
  logic       volup, voldown;
  logic [7:0] pb_in_port;
  logic       read_from_uart, write_to_uart;
  logic       record, play, delete, pause, delete_all;
  logic [1:0] volume_control;

  pb_port_controller #(.DEBOUNCE_CYCLES(DB), .VOL_RESET(2'd1)) dut (
    .clk100mhz         (clk100mhz),
    .pb_reset          (pb_reset),
    .pb_port_id        (pb_port_id),
    .pb_out_port       (pb_out_port),
    .pb_read_strobe    (pb_read_strobe),
    .pb_write_strobe   (pb_write_strobe),
    .uart_rx_data      (uart_rx_data),
    .uart_data_present (uart_data_present),
    .uart_buffer_full  (uart_buffer_full),
    .deletedall        (deletedall),
    .volup             (volup),
    .voldown           (voldown),
    .pb_in_port        (pb_in_port),
    .read_from_uart    (read_from_uart),
    .write_to_uart     (write_to_uart),
    .record            (record),
    .play              (play),
    .delete            (delete),
    .pause             (pause),
    .delete_all        (delete_all),
    .volume_control    (volume_control)
  );

  always #5 clk100mhz = ~clk100mhz;

  typedef enum int {K_INPORT, K_RDUART, K_WRUART, K_MODE, K_VOL} kind_e;
  typedef struct {
    kind_e      kind;
    int         at;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   mode_v = -1;  // selected transport code 0..4, -1 when none
  int   vol    = 1;

  always @(posedge clk100mhz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%02h expected 0x%02h", name, cyc, act, exp);
    end
  endtask

  // Mode bits packed as {record, play, delete, pause, delete_all}.
  function automatic logic [4:0] mode_bits(input int m);
    case (m)
      0:       return 5'b01000;
      1:       return 5'b10000;
      2:       return 5'b00100;
      3:       return 5'b00010;
      4:       return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [7:0] port_read(input logic [7:0] id, input logic [7:0] rx,
                                           input logic dp, input logic bf, input logic da);
    case (id)
      8'h02:   return rx;
      8'h04:   return {7'b0, dp};
      8'h05:   return {7'b0, bf};
      8'h07:   return {7'b0, da};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] dut_mode();
    return {3'b0, record, play, delete, pause, delete_all};
  endfunction

  task automatic push(input kind_e k, input int at, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.at   = at;
    e.val  = v;
    q.push_back(e);
  endtask

  always @(negedge clk100mhz) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      m_e = q.pop_front();
      case (m_e.kind)
        K_INPORT: check("pb_in_port", pb_in_port, m_e.val);
        K_RDUART: check("read_from_uart", {7'b0, read_from_uart}, m_e.val);
        K_WRUART: check("write_to_uart", {7'b0, write_to_uart}, m_e.val);
        K_MODE:   check("mode_bits", dut_mode(), m_e.val);
        default:  check("volume_control", {6'b0, volume_control}, m_e.val);
      endcase
    end
  end

  task automatic drive(input logic [7:0] id, input logic [7:0] outp, input logic rd,
                       input logic wr, input logic [7:0] rx, input logic dp,
                       input logic bf, input logic da);
    @(posedge clk100mhz);
    #1;
    pb_port_id        = id;
    pb_out_port       = outp;
    pb_read_strobe    = rd;
    pb_write_strobe   = wr;
    uart_rx_data      = rx;
    uart_data_present = dp;
    uart_buffer_full  = bf;
    deletedall        = da;
    push(K_WRUART, cyc, {7'b0, wr && (id == 8'h03)});
    push(K_INPORT, cyc + 1, port_read(id, rx, dp, bf, da));
    push(K_RDUART, cyc + 1, {7'b0, rd && (id == 8'h04)});
    if (wr && id == 8'h06) mode_v = (outp <= 8'h04) ? int'(outp) : -1;
    push(K_MODE, cyc + 1, {3'b0, mode_bits(mode_v)});
  endtask

  task automatic idle();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Hold a button for 'hold' raw cycles, release, let it settle, then check volume.
  task automatic press(input bit up, input int hold);
    @(posedge clk100mhz);
    #1;
    if (up) volup = 1'b1; else voldown = 1'b1;
    repeat (hold) @(posedge clk100mhz);
    #1;
    volup   = 1'b0;
    voldown = 1'b0;
    repeat (3 * DB + 4) @(posedge clk100mhz);
    #1;
    if (hold >= DB) vol = up ? ((vol < 3) ? vol + 1 : 3) : ((vol > 0) ? vol - 1 : 0);
    push(K_VOL, cyc, 8'(vol));
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk100mhz);
      budget--;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d expectations still pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    pb_reset          = 1'b1;
    pb_port_id        = 8'h00;
    pb_out_port       = 8'h00;
    pb_read_strobe    = 1'b0;
    pb_write_strobe   = 1'b0;
    uart_rx_data      = 8'h00;
    uart_data_present = 1'b0;
    uart_buffer_full  = 1'b0;
    deletedall        = 1'b0;
    volup             = 1'b0;
    voldown           = 1'b0;
    #2;
    check("reset_pb_in_port", pb_in_port, 8'h00);
    check("reset_read_from_uart", {7'b0, read_from_uart}, 8'h00);
    check("reset_mode", dut_mode(), 8'h00);
    check("reset_volume", {6'b0, volume_control}, 8'h01);
    repeat (2) @(posedge clk100mhz);
    #1;
    pb_reset = 1'b0;

    // Directed port mux and strobe cases.
    drive(8'h02, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    drive(8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h09, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
    drive(8'h03, 8'h41, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h04, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();

    // Directed mode writes, including a write to a non-mode port.
    drive(8'h06, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h06, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h05, 8'h02, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(8'h06, 8'h04, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h06, 8'h7F, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'h06, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();

    // Randomised traffic, biased toward the decoded port ids and mode codes.
    for (int i = 0; i < 250; i++) begin
      int r;
      logic [7:0] id, outp;
      r    = $urandom_range(0, 11);
      id   = (r < 10) ? 8'(r) : 8'($urandom_range(0, 255));
      outp = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      drive(id, outp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();
    drain("random_drain");

    // Volume: saturate up, saturate down, reject a glitch, climb back to 3.
    for (int i = 0; i < 3; i++) press(1'b1, 3 * DB);
    for (int i = 0; i < 4; i++) press(1'b0, 3 * DB);
    press(1'b1, 2);
    for (int i = 0; i < 3; i++) press(1'b1, 3 * DB);

    // Asynchronous reset mid-cycle with play selected and volume at 3.
    drive(8'h06, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    drain("pre_reset_drain");
    @(posedge clk100mhz);
    #2;
    pb_reset = 1'b1;
    #1;
    mode_v = -1;
    vol    = 1;
    check("async_reset_mode", dut_mode(), 8'h00);
    check("async_reset_volume", {6'b0, volume_control}, 8'(vol));
    @(posedge clk100mhz);
    #1;
    pb_reset = 1'b0;
    idle();
    press(1'b1, 3 * DB);
    idle();
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
